// File: rtl/alu_rr_arbiter_if.sv
// Request/response bundle between the requester clients and the ALU arbiter.
// Requester i owns bits [i] of req_valid/req_ready, [8i+7:8i] of req_a/req_b, [2i+1:2i] of req_op.
// master = client side (drives requests, accepts responses); slave = arbiter side.
interface alu_rr_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ*8-1:0] req_a;
  logic [NUM_REQ*8-1:0] req_b;
  logic [NUM_REQ*2-1:0] req_op;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [ID_W-1:0]      rsp_id;
  logic [7:0]           rsp_result;
  logic [2:0]           rsp_flags;

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_flags
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_result, rsp_flags
  );
endinterface

// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one registered 8-bit ALU among NUM_REQ requesters.
// Latency: accept edge to rsp_valid high is 2 clocks; one transaction in flight at a time.
// Backpressure: response held stable until rsp_ready; req_ready only asserted in IDLE.
module alu_rr_arbiter #(
  parameter int NUM_REQ = 4,  // 2..8
  parameter int ID_W    = 2   // must equal $clog2(NUM_REQ) and match the interface
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_rr_arbiter_if.slave    bus,
  output logic [7:0]         alu_a,
  output logic [7:0]         alu_b,
  output logic [1:0]         alu_opcode,
  input  logic [7:0]         alu_result,
  input  logic               alu_zero,
  input  logic               alu_carry,
  input  logic               alu_overflow,
  output logic               busy
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ISSUE   = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;
  localparam logic [1:0] RESP    = 2'd3;

  logic [1:0]      state;
  logic [ID_W-1:0] last_grant;
  logic [ID_W-1:0] cur_id;
  logic [ID_W-1:0] win_id;
  logic [ID_W-1:0] cand;
  logic            win_found;
  logic            accept;

  // Search for the first valid requester after last_grant, wrapping modulo NUM_REQ
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ID_W'((int'(last_grant) + k) % NUM_REQ);
      if (!win_found && bus.req_valid[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  // The winner is always valid, so offering ready to it in IDLE is an accept
  always_comb begin
    accept        = (state == IDLE) && win_found;
    bus.req_ready = '0;
    if (accept) bus.req_ready[win_id] = 1'b1;
    busy          = (state != IDLE);
  end

  // FSM sequencing; priority pointer moves only when a request is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= ID_W'(NUM_REQ - 1);
      cur_id     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            state      <= ISSUE;
            last_grant <= win_id;
            cur_id     <= win_id;
          end
        end
        ISSUE:   state <= CAPTURE;
        CAPTURE: state <= RESP;
        RESP:    if (bus.rsp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // ALU operands sampled from the winner only at the accept edge, then left untouched
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= '0;
    end else if (accept) begin
      alu_a      <= bus.req_a[8*int'(win_id) +: 8];
      alu_b      <= bus.req_b[8*int'(win_id) +: 8];
      alu_opcode <= bus.req_op[2*int'(win_id) +: 2];
    end
  end

  // Capture the ALU outputs verbatim in CAPTURE and hold them until the response is taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rsp_valid  <= 1'b0;
      bus.rsp_id     <= '0;
      bus.rsp_result <= '0;
      bus.rsp_flags  <= '0;
    end else if (state == CAPTURE) begin
      bus.rsp_valid  <= 1'b1;
      bus.rsp_id     <= cur_id;
      bus.rsp_result <= alu_result;
      bus.rsp_flags  <= {alu_overflow, alu_carry, alu_zero};
    end else if (state == RESP && bus.rsp_ready) begin
      bus.rsp_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Self-checking bench for alu_rr_arbiter with a registered ALU stand-in.
// Directed scenarios followed by a randomized phase against a transaction-level model.
// The model tracks one outstanding request by age in cycles since its accept.
`timescale 1ns/1ps
module tb_alu_rr_arbiter;
  localparam int N   = 4;
  localparam int IDW = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] alu_a, alu_b, alu_result;
  logic [1:0] alu_opcode;
  logic       alu_zero, alu_carry, alu_overflow, busy;

  alu_rr_arbiter_if #(.NUM_REQ(N), .ID_W(IDW)) bus ();

  alu_rr_arbiter #(.NUM_REQ(N), .ID_W(IDW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_carry(alu_carry),
    .alu_overflow(alu_overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  // Arithmetic reference: returns {overflow, carry, zero, result}
  function automatic logic [10:0] alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
    logic [8:0] s;
    logic       v;
    s = '0;
    v = 1'b0;
    case (op)
      2'b00: begin s = {1'b0, a} + {1'b0, b}; v = (a[7] == b[7]) && (s[7] != a[7]); end
      2'b01: begin s = {1'b0, a} - {1'b0, b}; v = (a[7] != b[7]) && (s[7] != a[7]); end
      2'b10: s = {1'b0, a & b};
      default: s = {1'b0, a | b};
    endcase
    return {v, s[8], (s[7:0] == 8'h00), s[7:0]};
  endfunction

  // Registered ALU stand-in: one clock from operands to outputs
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) {alu_overflow, alu_carry, alu_zero, alu_result} <= '0;
    else        {alu_overflow, alu_carry, alu_zero, alu_result} <= alu_ref(alu_a, alu_b, alu_opcode);
  end

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Transaction model
  int         m_last;
  bit         m_busy;
  int         m_age;
  int         t_id;
  logic [7:0] t_a, t_b;
  logic [1:0] t_op;

  // Observation logs
  int         acc_id[$];
  int         acc_cyc[$];
  int         rsp_start;
  int         rsp_obs;
  bit         prev_rsp;
  logic [7:0] seen_res;
  logic [2:0] seen_flg;
  int         seen_id;

  logic [N*8-1:0] da, db;
  logic [N*2-1:0] dop;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0;
    m_last = N - 1;
    m_age  = 0;
  endtask

  task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
    da[8*i +: 8]  = a;
    db[8*i +: 8]  = b;
    dop[2*i +: 2] = op;
  endtask

  task automatic clear_logs();
    acc_id.delete();
    acc_cyc.delete();
    rsp_obs   = 0;
    rsp_start = -1;
  endtask

  // One clock: drive at negedge, check against the model, then let the edge happen
  task automatic step(input logic [N-1:0] v, input logic rr);
    int         win;
    logic [10:0] g;
    @(negedge clk);
    bus.req_valid = v;
    bus.req_a     = da;
    bus.req_b     = db;
    bus.req_op    = dop;
    bus.rsp_ready = rr;
    #1;
    win = -1;
    if (!m_busy) begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_last + k) % N;
        if (win < 0 && v[c]) win = c;
      end
    end
    check("req_ready", 32'(bus.req_ready), (win >= 0) ? (32'd1 << win) : 32'd0);
    check("busy", 32'(busy), 32'(m_busy));
    check("rsp_valid", 32'(bus.rsp_valid), 32'(m_busy && m_age >= 2));
    if (m_busy) begin
      check("alu_a", 32'(alu_a), 32'(t_a));
      check("alu_b", 32'(alu_b), 32'(t_b));
      check("alu_opcode", 32'(alu_opcode), 32'(t_op));
    end
    if (m_busy && m_age >= 2) begin
      g = alu_ref(t_a, t_b, t_op);
      check("rsp_id", 32'(bus.rsp_id), 32'(t_id));
      check("rsp_result", 32'(bus.rsp_result), 32'(g[7:0]));
      check("rsp_flags", 32'(bus.rsp_flags), 32'(g[10:8]));
    end
    for (int i = 0; i < N; i++) begin
      if (bus.req_valid[i] === 1'b1 && bus.req_ready[i] === 1'b1) begin
        acc_id.push_back(i);
        acc_cyc.push_back(cyc);
      end
    end
    if (bus.rsp_valid === 1'b1) begin
      if (!prev_rsp) rsp_start = cyc;
      rsp_obs++;
      seen_res = bus.rsp_result;
      seen_flg = bus.rsp_flags;
      seen_id  = int'(bus.rsp_id);
    end
    prev_rsp = (bus.rsp_valid === 1'b1);
    // Advance the model across the coming edge
    if (!m_busy) begin
      if (win >= 0) begin
        m_busy = 1'b1;
        m_age  = 0;
        t_id   = win;
        t_a    = da[8*win +: 8];
        t_b    = db[8*win +: 8];
        t_op   = dop[2*win +: 2];
        m_last = win;
      end
    end else if (m_age >= 2) begin
      if (rr) m_busy = 1'b0;
    end else begin
      m_age++;
    end
    @(posedge clk);
    cyc++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_op    = '0;
    bus.rsp_ready = 1'b0;
    da = '0; db = '0; dop = '0;
    prev_rsp = 1'b0;
    seen_res = '0; seen_flg = '0; seen_id = -1;
    model_reset();
    clear_logs();
    #12;
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_alu", {14'd0, alu_a, alu_b, alu_opcode}, 32'd0);
    check("rst_rsp", {19'd0, bus.rsp_id, bus.rsp_result, bus.rsp_flags}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step('0, 1'b1);

    // All requesters valid: 0,1,2,3,0 four clocks apart
    for (int i = 0; i < N; i++) set_op(i, 8'(i * 3 + 1), 8'(i + 7), 2'(i));
    clear_logs();
    for (int s = 0; s < 20; s++) step('1, 1'b1);
    check("allv_count", acc_id.size(), 5);
    if (acc_id.size() >= 5) begin
      for (int i = 0; i < 5; i++) check("allv_order", acc_id[i], i % N);
      for (int i = 0; i < 4; i++) check("allv_spacing", acc_cyc[i+1] - acc_cyc[i], 4);
    end

    // Single request from requester 2: ADD 5+3
    set_op(2, 8'h05, 8'h03, 2'b00);
    clear_logs();
    step(4'b0100, 1'b1);
    for (int s = 0; s < 3; s++) step('0, 1'b1);
    check("single_acc", (acc_id.size() == 1) ? acc_id[0] : -1, 2);
    check("single_latency", (acc_cyc.size() == 1) ? rsp_start - acc_cyc[0] : -1, 3);
    check("single_id", seen_id, 2);
    check("single_result", 32'(seen_res), 32'h08);
    check("single_flags", 32'(seen_flg), 32'h0);

    // Rotation: after 2, requesters 1 and 3 -> 3 wins first
    set_op(1, 8'h11, 8'h22, 2'b11);
    set_op(3, 8'h33, 8'h0F, 2'b10);
    clear_logs();
    for (int s = 0; s < 8; s++) step(4'b1010, 1'b1);
    check("rot_count", acc_id.size(), 2);
    if (acc_id.size() >= 2) begin
      check("rot_first", acc_id[0], 3);
      check("rot_second", acc_id[1], 1);
    end

    // Backpressure: SUB 0x10-0x10 held for 5 RESP cycles, others requesting meanwhile
    set_op(0, 8'h10, 8'h10, 2'b01);
    clear_logs();
    step(4'b0001, 1'b0);
    for (int s = 0; s < 7; s++) step('1, 1'b0);
    step('0, 1'b1);
    step('0, 1'b1);
    check("bp_accepts", acc_id.size(), 1);
    check("bp_rsp_cycles", rsp_obs, 6);
    check("bp_result", 32'(seen_res), 32'h00);
    check("bp_zero", 32'(seen_flg[0]), 32'd1);

    // Carry path: ADD 0x80+0x80, then AND 0xF0&0x0F
    set_op(3, 8'h80, 8'h80, 2'b00);
    step(4'b1000, 1'b1);
    for (int s = 0; s < 3; s++) step('0, 1'b1);
    check("add80_result", 32'(seen_res), 32'h00);
    check("add80_carry", 32'(seen_flg[1]), 32'd1);
    check("add80_zero", 32'(seen_flg[0]), 32'd1);
    set_op(1, 8'hF0, 8'h0F, 2'b10);
    step(4'b0010, 1'b1);
    for (int s = 0; s < 3; s++) step('0, 1'b1);
    check("and_result", 32'(seen_res), 32'h00);
    check("and_carry", 32'(seen_flg[1]), 32'd0);
    check("and_zero", 32'(seen_flg[0]), 32'd1);

    // Reset while in CAPTURE: everything clears at once, no response
    set_op(2, 8'h7F, 8'h01, 2'b00);
    step(4'b0100, 1'b1);
    step('0, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_req_ready", 32'(bus.req_ready), 32'd0);
    check("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_alu", {14'd0, alu_a, alu_b, alu_opcode}, 32'd0);
    check("midrst_rsp", {19'd0, bus.rsp_id, bus.rsp_result, bus.rsp_flags}, 32'd0);
    model_reset();
    prev_rsp = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    clear_logs();
    step('0, 1'b1);
    step('0, 1'b1);
    check("midrst_no_rsp", rsp_obs, 0);
    step(4'b1010, 1'b1);
    check("postrst_first", (acc_id.size() >= 1) ? acc_id[0] : -1, 1);
    for (int s = 0; s < 3; s++) step('0, 1'b1);

    // Randomized traffic with changing data and intermittent backpressure
    for (int s = 0; s < 400; s++) begin
      da  = {$urandom};
      db  = {$urandom};
      dop = 8'($urandom);
      step(4'($urandom), ($urandom_range(0, 3) != 0));
    end
    for (int s = 0; s < 6; s++) step('0, 1'b1);
    check("drain_idle", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
